// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data memory.
// Contents:
//   PC_WIDTH, REG_WIDTH, DEPTH : default address width, data width and word count
//   WOFF                       : number of byte-offset bits below the word index
//   AW                         : number of word-index bits
//   addr_t, word_t             : byte-address and data-word types at the default widths
package cpu_mem_pkg;

    localparam int PC_WIDTH  = 32;
    localparam int REG_WIDTH = 32;
    localparam int DEPTH     = 256;

    localparam int WOFF = $clog2(REG_WIDTH / 8);
    localparam int AW   = $clog2(DEPTH);

    typedef logic [PC_WIDTH-1:0]  addr_t;
    typedef logic [REG_WIDTH-1:0] word_t;

endpackage

// File: rtl/cpu_mem_array.sv
// DEPTH x REG_WIDTH word storage.
// Ports:
//   clk     in   clock, all updates on posedge
//   reset   in   synchronous active-high clear of every word
//   wrEn    in   write wrData into word idx
//   idx     in   word index shared by the write and read ports
//   wrData  in   write data
//   rdWord  out  current contents of word idx; sampled by the caller's output register
module cpu_mem_array #(
    parameter  int REG_WIDTH = cpu_mem_pkg::REG_WIDTH,
    parameter  int DEPTH     = cpu_mem_pkg::DEPTH,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrEn,
    input  logic [IDX_W-1:0]     idx,
    input  logic [REG_WIDTH-1:0] wrData,
    output logic [REG_WIDTH-1:0] rdWord
);

    logic [REG_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[idx] <= wrData;
        end
    end

    // Read is combinational here; the caller's register samples it on the
    // same edge the write lands, which gives read-before-write behaviour.
    assign rdWord = mem[idx];

endmodule

// File: rtl/cpu_data_mem.sv
// Single-port synchronous data memory for the CPU load/store path.
// Ports:
//   clk        in   clock, all state changes on posedge
//   resetn     in   synchronous active-high reset (1 = reset); clears memory and memrdData
//   memWe      in   full-word write enable
//   memRd      in   read enable; memrdData updates on the following edge
//   memAdr     in   byte address shared by read and write
//   memwrData  in   write data
//   memrdData  out  registered read data, holds its value when memRd=0
module cpu_data_mem #(
    parameter int PC_WIDTH  = cpu_mem_pkg::PC_WIDTH,
    parameter int REG_WIDTH = cpu_mem_pkg::REG_WIDTH,
    parameter int DEPTH     = cpu_mem_pkg::DEPTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 memWe,
    input  logic                 memRd,
    input  logic [PC_WIDTH-1:0]  memAdr,
    input  logic [REG_WIDTH-1:0] memwrData,
    output logic [REG_WIDTH-1:0] memrdData
);

    import cpu_mem_pkg::*;

    localparam int WORD_OFF = $clog2(REG_WIDTH / 8);
    localparam int IDX_W    = $clog2(DEPTH);

    logic [IDX_W-1:0]     wordIdx;
    logic                 wrEn;
    logic [REG_WIDTH-1:0] rdWord;
    logic                 unusedAdr;

    // Byte-offset bits and bits above the index are dropped, so addresses
    // alias modulo DEPTH words and misaligned addresses hit the enclosing word.
    assign wordIdx   = memAdr[WORD_OFF +: IDX_W];
    assign unusedAdr = ^memAdr;

    assign wrEn = memWe & ~resetn;

    cpu_mem_array #(
        .REG_WIDTH (REG_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk    (clk),
        .reset  (resetn),
        .wrEn   (wrEn),
        .idx    (wordIdx),
        .wrData (memwrData),
        .rdWord (rdWord)
    );

    always_ff @(posedge clk) begin
        if (resetn) begin
            memrdData <= '0;
        end else if (memRd) begin
            memrdData <= rdWord;
        end
    end

endmodule

// File: tb/tb_cpu_data_mem.sv
module tb_cpu_data_mem;

    import cpu_mem_pkg::*;

    logic  clk = 1'b0;
    logic  resetn = 1'b1;
    logic  memWe = 1'b0;
    logic  memRd = 1'b0;
    addr_t memAdr = '0;
    word_t memwrData = '0;
    word_t memrdData;

    always #5 clk = ~clk;

    cpu_data_mem dut (
        .clk       (clk),
        .resetn    (resetn),
        .memWe     (memWe),
        .memRd     (memRd),
        .memAdr    (memAdr),
        .memwrData (memwrData),
        .memrdData (memrdData)
    );

    word_t model [DEPTH];
    word_t lastOut = '0;
    word_t expQ [$];
    int    checkCnt = 0;
    int    passCnt = 0;

    // Drive one request and record the value memrdData must show after the edge.
    task automatic step(input logic rst, input logic we, input logic rd,
                        input addr_t adr, input word_t wd);
        int    idx;
        word_t expVal;
        @(negedge clk);
        resetn    = rst;
        memWe     = we;
        memRd     = rd;
        memAdr    = adr;
        memwrData = wd;
        idx = int'((adr / (REG_WIDTH / 8)) % DEPTH);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            expVal = '0;
        end else begin
            expVal = rd ? model[idx] : lastOut;
            if (we) model[idx] = wd;
        end
        lastOut = expVal;
        expQ.push_back(expVal);
    endtask

    // Monitor: one expected value per issued cycle, compared just after the edge.
    initial begin
        word_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkCnt++;
                if (memrdData === e) passCnt++;
                else $display("FAIL rdData t=%0t got %h expected %h", $time, memrdData, e);
            end
        end
    end

    initial begin
        logic  rRst;
        logic  rWe;
        logic  rRd;
        addr_t rAdr;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // reset, then reads of cleared memory
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h000, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h3FC, 32'h0);

        // write / readback
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h12345678);
        step(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h14, 32'h0);

        // same-cycle read and write returns old data
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'hAAAA5555);
        step(1'b0, 1'b1, 1'b1, 32'h20, 32'h0F0F0F0F);
        step(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);

        // aliasing and ignored byte offset
        step(1'b0, 1'b1, 1'b0, 32'h400, 32'hCAFEF00D);
        step(1'b0, 1'b0, 1'b1, 32'h000, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h003, 32'h0);

        // hold while idle
        step(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset in the middle of a write
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h55667788);
        step(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);

        // random traffic, half of it confined to 16 words with random alias/offset bits
        for (int n = 0; n < 3000; n++) begin
            rRst = ($urandom_range(0, 63) == 0);
            rWe  = 1'($urandom_range(0, 1));
            rRd  = 1'($urandom_range(0, 1));
            rAdr = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() & 32'hFFFF_F03F);
            step(rRst, rWe, rRd, rAdr, $urandom());
        end

        @(negedge clk);
        memWe = 1'b0;
        memRd = 1'b0;
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            checkCnt++;
            $display("FAIL drain: %0d responses outstanding, required 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
